// File: rtl/run_seq_pkg.sv
// rtl/run_seq_pkg.sv - state encoding shared by the run sequencer blocks
package run_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_RUN   = 3'd3,
        ST_STEP  = 3'd4,
        ST_HALT  = 3'd5
    } state_e;

    function automatic state_e exec_state(input logic step_mode);
        return step_mode ? ST_STEP : ST_RUN;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - program load, run, single-step and breakpoint controller
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = 200_000_000,
    parameter int          CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pg_req,
    input  logic             start_req,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             upg_done_i,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    output logic             upg_rst_o,
    output logic             cpu_rst_o,
    output logic             cpu_en,
    output logic [2:0]       state_o,
    output logic             halted,
    output logic             load_err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int TMO_W = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOAD_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             load_err_q, load_err_d;
    logic             bp_mask_q, bp_mask_d;
    logic             bp_hit;
    logic             load_entry;
    logic             unused_addr_bits;

    // Only word addresses are compared; byte offset bits carry no meaning here.
    assign unused_addr_bits = ^{pc[1:0], bp_addr[1:0]};
    assign bp_hit = bp_en && (pc[31:2] == bp_addr[31:2]) && !bp_mask_q;

    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        load_err_d = load_err_q;
        bp_mask_d  = bp_mask_q;
        cpu_en     = 1'b0;
        load_entry = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pg_req)         state_d = ST_LOAD;
                else if (start_req) state_d = exec_state(step_mode);
            end
            ST_LOAD: begin
                if (upg_done_i) begin
                    state_d = ST_READY;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d    = ST_IDLE;
                    load_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (pg_req)         state_d = ST_LOAD;
                else if (start_req) state_d = exec_state(step_mode);
            end
            ST_RUN: begin
                cpu_en = !bp_hit;
                if (pg_req)         state_d = ST_LOAD;
                else if (bp_hit)    state_d = ST_HALT;
                else if (step_mode) state_d = ST_STEP;
            end
            ST_STEP: begin
                cpu_en = step_req;
                if (pg_req)          state_d = ST_LOAD;
                else if (!step_mode) state_d = ST_RUN;
            end
            ST_HALT: begin
                if (pg_req)         state_d = ST_LOAD;
                else if (start_req) state_d = exec_state(step_mode);
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
            load_entry = 1'b1;
            tmo_cnt_d  = '0;
            load_err_d = 1'b0;
        end

        // Resuming from a breakpoint must let the halted instruction through once.
        if ((state_q == ST_HALT) && (state_d != ST_HALT)) begin
            bp_mask_d = 1'b1;
        end else if (cpu_en) begin
            bp_mask_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            tmo_cnt_q  <= '0;
            load_err_q <= 1'b0;
            bp_mask_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_cnt_q  <= tmo_cnt_d;
            load_err_q <= load_err_d;
            bp_mask_q  <= bp_mask_d;
        end
    end

    always_comb begin
        upg_rst_o = (state_q != ST_LOAD);
        cpu_rst_o = !((state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_HALT));
        halted    = (state_q == ST_HALT);
        state_o   = state_q;
        load_err  = load_err_q;
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_instr_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (cpu_en),
        .clr   (load_entry),
        .count (instr_count)
    );

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Central run/program-load controller for the single-cycle MIPS CPU: sequences UART program loading, CPU reset release, free-run, single-step and PC breakpoint halt. Sits in the top level between the debounced button pulses and the UART programmer, instruction fetch and decode blocks. Drives the UART reset, the CPU reset and a per-cycle CPU clock enable, and counts retired instructions.

## Interface
Parameters:
- LOAD_TIMEOUT, 200_000_000: cycles allowed in LOAD without `upg_done_i` before aborting (10 s at 20 MHz).
- CNT_W, 32: width of `instr_count`.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state to IDLE.
- pg_req  in  1  one-cycle pulse: request program load.
- start_req  in  1  one-cycle pulse: start/resume execution.
- step_mode  in  1  level: 1 selects single-step execution.
- step_req  in  1  one-cycle pulse: execute one instruction in STEP.
- upg_done_i  in  1  UART programmer finished (level).
- bp_en  in  1  breakpoint enable.
- bp_addr  in  32  breakpoint PC (word aligned; bits [1:0] ignored).
- pc  in  32  current fetch PC.
- upg_rst_o  out  1  UART programmer reset, active-high.
- cpu_rst_o  out  1  CPU reset, active-high.
- cpu_en  out  1  CPU advances one instruction on this cycle's edge (combinational).
- state_o  out  3  current state encoding.
- halted  out  1  1 in HALT.
- load_err  out  1  sticky: last LOAD timed out.
- instr_count  out  CNT_W  number of cycles with `cpu_en`=1.

## Operation
- States: IDLE=0, LOAD=1, READY=2, RUN=3, STEP=4, HALT=5; 6/7 illegal -> IDLE next cycle.
- Outputs per state: upg_rst_o=0 only in LOAD, else 1; cpu_rst_o=1 in IDLE/LOAD/READY, 0 in RUN/STEP/HALT; halted=1 only in HALT.
- IDLE: pg_req -> LOAD; start_req -> RUN (step_mode=0) or STEP (step_mode=1).
- LOAD: clears instr_count and load_err on entry; timeout counter starts at 0. upg_done_i=1 -> READY. Counter reaching LOAD_TIMEOUT-1 without done -> IDLE, load_err=1. pg_req and start_req ignored.
- READY: start_req -> RUN/STEP by step_mode; pg_req -> LOAD.
- RUN: cpu_en = !bp_hit. bp_hit = bp_en & (pc[31:2]==bp_addr[31:2]) & !bp_mask. bp_hit -> HALT (that instruction not executed). step_mode=1 -> STEP.
- STEP: cpu_en = step_req; breakpoints ignored. step_mode=0 -> RUN.
- HALT: cpu_en=0; start_req -> RUN/STEP by step_mode.
- bp_mask: set on leaving HALT, cleared after the first cycle with cpu_en=1, so resume executes the breakpointed instruction once.
- pg_req in READY/RUN/STEP/HALT -> LOAD (aborts execution, CPU back in reset).
- Priority on same cycle: pg_req > bp_hit > start_req > step_mode change.
- instr_count increments when cpu_en=1; saturates at all-ones; unchanged otherwise.

## Timing
- Reset (asserted low, async): state IDLE, upg_rst_o=1, cpu_rst_o=1, cpu_en=0, halted=0, load_err=0, instr_count=0, bp_mask=0, timeout counter 0.
- Deassertion is sampled on the next rising edge; first transition earliest one cycle after release.
- State transitions: one cycle after the triggering input; registered outputs follow in the same cycle as the new state.
- cpu_en is combinational from state, bp_hit and step_req; zero-latency so a breakpoint stops before the matching instruction commits.
- LOAD->READY one cycle after upg_done_i seen high; done already high on LOAD entry -> READY after exactly one LOAD cycle.
- Timeout: exactly LOAD_TIMEOUT cycles spent in LOAD before IDLE.

## Structure
- Shared package `run_seq_pkg`: state encoding constants (IDLE..HALT), state width 3.
- One sub-module `sat_counter` (parameter width; inc, clr, saturating) for instr_count. Timeout counter is inline.
- Single always block for state/registers with async active-low reset; combinational block for cpu_en and next state.

## Test plan
- Reset low mid-RUN with instr_count=5 -> next cycle state_o=0, cpu_rst_o=1, upg_rst_o=1, instr_count=0.
- pg_req, upg_done_i high after 10 cycles, start_req with step_mode=0 -> state 1 then 2 then 3; upg_rst_o=0 for exactly 11 cycles; cpu_en=1 from RUN's first cycle.
- LOAD_TIMEOUT=16, pg_req, no done -> IDLE after 16 cycles, load_err=1; next pg_req clears load_err.
- RUN with bp_en=1, bp_addr=0x0000_0010, pc stepping 0x0,0x4,... -> cpu_en=0 when pc=0x10, HALT, instr_count=4; start_req -> cpu_en=1 at pc=0x10 once, no re-halt.
- step_mode=1, three step_req pulses 5 cycles apart -> cpu_en high exactly 3 single cycles, instr_count=3; bp at current pc ignored.
- pg_req and start_req same cycle in READY -> LOAD; pg_req and bp_hit same cycle in RUN -> LOAD, instr_count cleared.
